debounce_scheduler: RTL
=======================

# debounce_scheduler

- Time-shared debounce controller for `CHANNELS` raw switch/button inputs.
- One stability counter serves all channels. A round-robin scheduler picks one channel at a time whose input differs from its debounced level and times it.
- A change that holds for `STABLE_CYCLES` commits the new level and reports it to the control unit as an event over a valid/ready handshake.

## Interface
Parameters:
- `CHANNELS`, 4: number of switch inputs (≥2).
- `STABLE_CYCLES`, 2000000: cycles a new level must persist (40 ms at 50 MHz); must be ≥2.
- `CW`, $clog2(STABLE_CYCLES): counter width, derived.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `sw_raw` input CHANNELS: asynchronous raw switch levels.
- `sw_stable` output CHANNELS: committed debounced levels.
- `ev_valid` output 1: event pending.
- `ev_ready` input 1: control unit accepts the event.
- `ev_channel` output $clog2(CHANNELS): channel of the pending event.
- `ev_level` output 1: new level of that channel.
- `busy` output 1: high in COUNT or REPORT.

## Operation
- `sw_s` is the per-channel conditioned input (see Configuration). A channel is *dirty* when `sw_s[i] != sw_stable[i]`.
- Registered state: `state`, `ptr`, `cur`, `cnt[CW-1:0]`, `sw_stable`, event registers.
- FSM states:
  - **SCAN**
    - Search for dirty channels, starting at `ptr` and wrapping from CHANNELS-1 to 0.
    - On the first hit: `cur`←index, `cnt`←0, go to COUNT.
    - No hit: stay in SCAN.
  - **COUNT**
    - `cnt` increments each cycle.
    - If `sw_s[cur] == sw_stable[cur]` (bounce back): go to SCAN, `ptr`←cur+1 (mod CHANNELS), no event.
    - Otherwise, when `cnt == STABLE_CYCLES-1`:
      - `sw_stable[cur]`←`sw_s[cur]`
      - `ev_channel`←cur, `ev_level`←`sw_s[cur]`, `ev_valid`←1
      - go to REPORT.
    - The bounce check has priority over the terminal count in the same cycle.
  - **REPORT**
    - Hold `ev_valid` and the event fields stable until `ev_ready` is high.
    - On the `ev_valid && ev_ready` cycle: `ev_valid`←0, `ptr`←cur+1 (mod CHANNELS), go to SCAN.
- `ev_ready` is ignored while `ev_valid` is low.
- Other channels are not timed during COUNT or REPORT. They stay dirty and are served in round-robin order later.
- A channel that toggles and reverts while waiting is never reported.
- At most one event is outstanding. The scheduler stalls in REPORT, so no event is ever lost or overwritten.

## Timing
- Reset values:
  - state = SCAN, `ptr` = 0, `cur` = 0, `cnt` = 0
  - `sw_stable` = 0, `ev_valid` = 0, `ev_channel` = 0, `ev_level` = 0, `busy` = 0
  - synchronizer flops = 0.
- Reset mid-count or mid-REPORT discards the operation. No event is emitted.
- Latency from the `sw_raw` edge to `ev_valid` for an idle scheduler: S + 1 + STABLE_CYCLES cycles.
  - S = 2 with synchronizer, 0 without.
  - The extra 1 is the SCAN decision cycle.
- `sw_stable` updates in the same cycle `ev_valid` rises.
- The earliest next SCAN decision is the cycle after the handshake.
- All outputs are registered.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: each `sw_raw` bit passes through a 2-flop synchronizer to form `sw_s`.
- Not defined: `sw_s = sw_raw` directly (inputs already synchronous to `clk`), and latency drops by 2.

## Structure
- Shared package `debounce_pkg` holds:
  - state encodings SCAN = 2'b00, COUNT = 2'b01, REPORT = 2'b10
  - the default `STABLE_CYCLES` constant.
- Sub-module `debounce_rr_pick`: combinational rotate-priority finder.
  - Inputs: dirty vector, `ptr`.
  - Outputs: `hit`, index.

## Test plan
All scenarios use CHANNELS=4, STABLE_CYCLES=8, `DEBOUNCE_SYNC_EN` defined.
- **Clean press:** `sw_raw[2]` 0→1 and held, `ev_ready`=1 → `ev_valid` pulses 1 cycle, 11 cycles after the edge, with `ev_channel`=2, `ev_level`=1; `sw_stable`=4'b0100.
- **Bounce:** `sw_raw[1]` high for 4 cycles then low → no event; `sw_stable` stays 0; FSM returns to SCAN.
- **Round robin:** `sw_raw[3]` and `sw_raw[0]` rise together after reset → events in order ch0, then ch3. Repeating with `ptr`=1 gives ch3, then ch0.
- **Back-pressure:** `ev_ready`=0 for 20 cycles while ch1 event pending and ch2 changes → `ev_valid` and fields held; ch2 event follows only after acceptance.
- **Reset mid-count:** `rst` asserted at `cnt`=5 → all outputs at reset values; no event.
- **Release:** after the clean press, `sw_raw[2]` 1→0 → event `ev_channel`=2, `ev_level`=0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the time-shared debounce controller.
//   state_t               - scheduler FSM encoding
//   DEFAULT_STABLE_CYCLES - default hold time (40 ms at 50 MHz)
package debounce_pkg;

  typedef enum logic [1:0] {
    SCAN   = 2'b00,
    COUNT  = 2'b01,
    REPORT = 2'b10
  } state_t;

  localparam int DEFAULT_STABLE_CYCLES = 2000000;

endpackage

// File: rtl/debounce_rr_pick.sv
// debounce_rr_pick
// Combinational rotate-priority finder. Returns the first set bit of
// dirty, searching upward from ptr and wrapping from N-1 back to 0.
// Ports:
//   dirty [N-1:0]  - candidate vector
//   ptr   [PW-1:0] - index searched first
//   hit            - at least one bit of dirty is set
//   idx   [PW-1:0] - index of the first set bit (0 when no hit)
module debounce_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  dirty,
  input  logic [PW-1:0] ptr,
  output logic          hit,
  output logic [PW-1:0] idx
);

  always_comb begin
    int j;
    logic [PW-1:0] jj;
    j   = 0;
    jj  = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = PW'(j);
      if (!hit && dirty[jj]) begin
        hit = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler
// Debounces CHANNELS raw switch inputs with a single shared stability
// counter. A round-robin scheduler times one changed channel at a time;
// a level that holds for STABLE_CYCLES is committed to sw_stable and
// reported as an event over a valid/ready handshake.
//
// Build option: define DEBOUNCE_SYNC_EN to pass every sw_raw bit through a
// 2-flop synchronizer (adds 2 cycles of latency). Without it sw_raw must
// already be synchronous to clk.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   sw_raw     - raw switch levels
//   sw_stable  - committed debounced levels
//   ev_valid   - event pending
//   ev_ready   - consumer accepts the event
//   ev_channel - channel of the pending event
//   ev_level   - new level of that channel
//   busy       - scheduler is timing or reporting a channel
//
// state  | meaning
// -------+-----------------------------------------------------------
// SCAN   | look for a channel whose input differs from sw_stable
// COUNT  | time channel cur; abort on bounce-back, commit on terminal
// REPORT | hold the event until ev_ready accepts it
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CW            = $clog2(STABLE_CYCLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         sw_raw,
  output logic [CHANNELS-1:0]         sw_stable,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [$clog2(CHANNELS)-1:0] ev_channel,
  output logic                        ev_level,
  output logic                        busy
);

  localparam int PW = $clog2(CHANNELS);

  logic [CHANNELS-1:0] sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign sw_s = sync_q2;
`else
  assign sw_s = sw_raw;
`endif

  state_t              state, state_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [PW-1:0]       cur, cur_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [CHANNELS-1:0] stable_n;
  logic                ev_valid_n;
  logic [PW-1:0]       ev_channel_n;
  logic                ev_level_n;

  logic [CHANNELS-1:0] dirty;
  logic                hit;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       cur_inc;

  assign dirty   = sw_s ^ sw_stable;
  assign cur_inc = (cur == PW'(CHANNELS - 1)) ? '0 : cur + PW'(1);

  debounce_rr_pick #(
    .N  (CHANNELS),
    .PW (PW)
  ) u_pick (
    .dirty (dirty),
    .ptr   (ptr),
    .hit   (hit),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    cur_n        = cur;
    cnt_n        = cnt;
    stable_n     = sw_stable;
    ev_valid_n   = ev_valid;
    ev_channel_n = ev_channel;
    ev_level_n   = ev_level;

    case (state)
      SCAN: begin
        if (hit) begin
          cur_n   = pick_idx;
          cnt_n   = '0;
          state_n = COUNT;
        end
      end

      COUNT: begin
        cnt_n = cnt + CW'(1);
        // A bounce back wins over a terminal count in the same cycle.
        if (sw_s[cur] == sw_stable[cur]) begin
          ptr_n   = cur_inc;
          state_n = SCAN;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          stable_n[cur] = sw_s[cur];
          ev_valid_n    = 1'b1;
          ev_channel_n  = cur;
          ev_level_n    = sw_s[cur];
          state_n       = REPORT;
        end
      end

      REPORT: begin
        if (ev_valid && ev_ready) begin
          ev_valid_n = 1'b0;
          ptr_n      = cur_inc;
          state_n    = SCAN;
        end
      end

      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      ptr        <= '0;
      cur        <= '0;
      cnt        <= '0;
      sw_stable  <= '0;
      ev_valid   <= 1'b0;
      ev_channel <= '0;
      ev_level   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cur        <= cur_n;
      cnt        <= cnt_n;
      sw_stable  <= stable_n;
      ev_valid   <= ev_valid_n;
      ev_channel <= ev_channel_n;
      ev_level   <= ev_level_n;
      busy       <= (state_n != SCAN);
    end
  end

endmodule
